// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core front end.
// Holds the LM/SM opcode constants, the load/store-multiple sequencer state
// encoding and the default register-index width.
package risc_pkg;

  // Opcodes of the two multi-register memory instructions.
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  // Default architectural register count and the matching index width.
  localparam int REGS_DEFAULT = 8;
  localparam int REG_IDX_W    = $clog2(REGS_DEFAULT);

  // Sequencer states: IDLE waits for decode, RUN issues micro-ops.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage : risc_pkg

// File: rtl/lsb_pri_enc.sv
// Lowest-set-bit priority encoder for the LM/SM register list.
// Ports:
//   vec       in  W    : register mask
//   idx       out IW   : index of the lowest set bit (0 when vec is 0)
//   one_left  out 1    : vec has exactly one bit set
//   mask_next out W    : vec with its lowest set bit cleared
module lsb_pri_enc #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          one_left,
  output logic [W-1:0]  mask_next
);

  logic [W-1:0] vec_m1;
  logic         found;

  // vec - 1 flips the lowest set bit and every zero below it.
  assign vec_m1    = vec - W'(1);
  assign mask_next = vec & vec_m1;
  // Exactly one bit set: non-zero, and clearing the lowest bit leaves nothing.
  assign one_left  = (vec != {W{1'b0}}) && (mask_next == {W{1'b0}});

  // Scan upward and latch the first set bit found.
  always_comb begin
    idx   = {IW{1'b0}};
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vec[i] && !found) begin
        idx   = IW'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule : lsb_pri_enc

// File: rtl/lmsm_seq.sv
// Load-multiple / store-multiple sequencer.
// Expands an LM/SM register list into one single-register micro-op per set
// bit, lowest register first, at consecutive word addresses.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, is_sm        : decode presents LM (is_sm=0) or SM (is_sm=1)
//   reg_list, base_addr : register mask and first word address
//   stall               : downstream stall, holds the current micro-op
//   busy                : sequencer owns the issue slot
//   uop_valid/lm/sm     : micro-op valid and its load/store tag
//   uop_reg, uop_addr   : register index and word address of the micro-op
//   uop_last            : final micro-op of the instruction
//   done                : one-cycle pulse after the instruction completes
module lmsm_seq
  import risc_pkg::*;
#(
  parameter int REGS = 8,
  parameter int AW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_sm,
  input  logic [REGS-1:0]         reg_list,
  input  logic [AW-1:0]           base_addr,
  input  logic                    stall,
  output logic                    busy,
  output logic                    uop_valid,
  output logic                    uop_lm,
  output logic                    uop_sm,
  output logic [$clog2(REGS)-1:0] uop_reg,
  output logic [AW-1:0]           uop_addr,
  output logic                    uop_last,
  output logic                    done
);

  localparam int IW = $clog2(REGS);

  seq_state_t      state_q, state_d;
  logic [REGS-1:0] mask_q, mask_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            sm_q, sm_d;
  logic            done_q, done_d;

  logic [IW-1:0]   enc_idx;
  logic            enc_one_left;
  logic [REGS-1:0] enc_mask_next;
  logic            run;

  lsb_pri_enc #(
    .W  (REGS),
    .IW (IW)
  ) u_enc (
    .vec       (mask_q),
    .idx       (enc_idx),
    .one_left  (enc_one_left),
    .mask_next (enc_mask_next)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= {REGS{1'b0}};
      addr_q  <= {AW{1'b0}};
      sm_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      sm_q    <= sm_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: capture on start, advance one register per accepted micro-op.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    sm_d    = sm_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (reg_list != {REGS{1'b0}}) begin
            mask_d  = reg_list;
            addr_d  = base_addr;
            sm_d    = is_sm;
            state_d = RUN;
          end else begin
            // Empty list completes immediately without issuing anything.
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start is ignored here; decode is held off by busy.
        if (!stall) begin
          mask_d = enc_mask_next;
          addr_d = addr_q + AW'(1);
          if (enc_one_left) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = {REGS{1'b0}};
        addr_d  = {AW{1'b0}};
        sm_d    = 1'b0;
      end
    endcase
  end

  // Micro-op outputs decode registered state only and are zeroed outside RUN.
  assign run       = (state_q == RUN);
  assign busy      = run;
  assign uop_valid = run;
  assign uop_lm    = run & ~sm_q;
  assign uop_sm    = run & sm_q;
  assign uop_reg   = run ? enc_idx : {IW{1'b0}};
  assign uop_addr  = run ? addr_q : {AW{1'b0}};
  assign uop_last  = run & enc_one_left;
  assign done      = done_q;

endmodule : lmsm_seq

// File: tb/tb_lmsm_seq.sv
// Directed self-checking bench for lmsm_seq.
module tb_lmsm_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_sm;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        stall;
  logic        busy;
  logic        uop_valid;
  logic        uop_lm;
  logic        uop_sm;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
  logic        uop_last;
  logic        done;

  int checks   = 0;
  int failures = 0;

  lmsm_seq #(.REGS(8), .AW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_sm     (is_sm),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .stall     (stall),
    .busy      (busy),
    .uop_valid (uop_valid),
    .uop_lm    (uop_lm),
    .uop_sm    (uop_sm),
    .uop_reg   (uop_reg),
    .uop_addr  (uop_addr),
    .uop_last  (uop_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check every output against the expected micro-op view.
  task automatic chk_all(input string tag, input logic e_busy, input logic e_lm,
                         input logic e_sm, input logic [2:0] e_reg,
                         input logic [15:0] e_addr, input logic e_last,
                         input logic e_done);
    chk({tag, ".busy"},  32'(busy),      32'(e_busy));
    chk({tag, ".valid"}, 32'(uop_valid), 32'(e_busy));
    chk({tag, ".lm"},    32'(uop_lm),    32'(e_lm));
    chk({tag, ".sm"},    32'(uop_sm),    32'(e_sm));
    chk({tag, ".reg"},   32'(uop_reg),   32'(e_reg));
    chk({tag, ".addr"},  32'(uop_addr),  32'(e_addr));
    chk({tag, ".last"},  32'(uop_last),  32'(e_last));
    chk({tag, ".done"},  32'(done),      32'(e_done));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_sm     = 1'b0;
    reg_list  = 8'h00;
    base_addr = 16'h0000;
    stall     = 1'b0;
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

    // LM 0x25 @0x0100.
    start = 1'b1; is_sm = 1'b0; reg_list = 8'h25; base_addr = 16'h0100;
    tick();
    start = 1'b0; reg_list = 8'h00; base_addr = 16'h0000;
    chk_all("lm25.u0", 1'b1, 1'b1, 1'b0, 3'd0, 16'h0100, 1'b0, 1'b0);
    tick();
    chk_all("lm25.u1", 1'b1, 1'b1, 1'b0, 3'd2, 16'h0101, 1'b0, 1'b0);
    tick();
    chk_all("lm25.u2", 1'b1, 1'b1, 1'b0, 3'd5, 16'h0102, 1'b1, 1'b0);
    tick();
    chk_all("lm25.done", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    tick();
    chk_all("lm25.idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

    // SM 0xFF @0xFFFE, address wraps after 0xFFFF.
    start = 1'b1; is_sm = 1'b1; reg_list = 8'hFF; base_addr = 16'hFFFE;
    tick();
    start = 1'b0; is_sm = 1'b0; reg_list = 8'h00; base_addr = 16'h0000;
    chk_all("smff.u0", 1'b1, 1'b0, 1'b1, 3'd0, 16'hFFFE, 1'b0, 1'b0);
    tick();
    chk_all("smff.u1", 1'b1, 1'b0, 1'b1, 3'd1, 16'hFFFF, 1'b0, 1'b0);
    tick();
    chk_all("smff.u2", 1'b1, 1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, 1'b0);
    tick();
    chk_all("smff.u3", 1'b1, 1'b0, 1'b1, 3'd3, 16'h0001, 1'b0, 1'b0);
    tick();
    chk_all("smff.u4", 1'b1, 1'b0, 1'b1, 3'd4, 16'h0002, 1'b0, 1'b0);
    tick();
    chk_all("smff.u5", 1'b1, 1'b0, 1'b1, 3'd5, 16'h0003, 1'b0, 1'b0);
    tick();
    chk_all("smff.u6", 1'b1, 1'b0, 1'b1, 3'd6, 16'h0004, 1'b0, 1'b0);
    tick();
    chk_all("smff.u7", 1'b1, 1'b0, 1'b1, 3'd7, 16'h0005, 1'b1, 1'b0);
    tick();
    chk_all("smff.done", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);

    // start coincident with done: LM 0x81 @0x0200, stalled 3 cycles on reg 0.
    start = 1'b1; is_sm = 1'b0; reg_list = 8'h81; base_addr = 16'h0200;
    tick();
    start = 1'b0; reg_list = 8'h00; base_addr = 16'h0000;
    chk_all("lm81.u0", 1'b1, 1'b1, 1'b0, 3'd0, 16'h0200, 1'b0, 1'b0);
    stall = 1'b1;
    // A start mid-sequence must be ignored.
    start = 1'b1; is_sm = 1'b1; reg_list = 8'h3C; base_addr = 16'h7777;
    tick();
    start = 1'b0; is_sm = 1'b0; reg_list = 8'h00; base_addr = 16'h0000;
    chk_all("lm81.st1", 1'b1, 1'b1, 1'b0, 3'd0, 16'h0200, 1'b0, 1'b0);
    tick();
    chk_all("lm81.st2", 1'b1, 1'b1, 1'b0, 3'd0, 16'h0200, 1'b0, 1'b0);
    tick();
    chk_all("lm81.st3", 1'b1, 1'b1, 1'b0, 3'd0, 16'h0200, 1'b0, 1'b0);
    stall = 1'b0;
    tick();
    chk_all("lm81.u1", 1'b1, 1'b1, 1'b0, 3'd7, 16'h0201, 1'b1, 1'b0);
    tick();
    chk_all("lm81.done", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    tick();
    chk_all("lm81.idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

    // Empty list: no micro-op, done at T+1.
    start = 1'b1; is_sm = 1'b1; reg_list = 8'h00; base_addr = 16'h1234;
    tick();
    start = 1'b0; is_sm = 1'b0; base_addr = 16'h0000;
    chk_all("empty.t1", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    tick();
    chk_all("empty.t2", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

    // Reset on the 2nd micro-op of 0x0F, then a fresh instruction.
    start = 1'b1; is_sm = 1'b1; reg_list = 8'h0F; base_addr = 16'h0300;
    tick();
    start = 1'b0; is_sm = 1'b0; reg_list = 8'h00; base_addr = 16'h0000;
    chk_all("rst0f.u0", 1'b1, 1'b0, 1'b1, 3'd0, 16'h0300, 1'b0, 1'b0);
    tick();
    chk_all("rst0f.u1", 1'b1, 1'b0, 1'b1, 3'd1, 16'h0301, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_all("rst0f.rst", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("rst0f.idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    start = 1'b1; is_sm = 1'b0; reg_list = 8'h0A; base_addr = 16'h0400;
    tick();
    start = 1'b0; reg_list = 8'h00; base_addr = 16'h0000;
    chk_all("new0a.u0", 1'b1, 1'b1, 1'b0, 3'd1, 16'h0400, 1'b0, 1'b0);
    tick();
    chk_all("new0a.u1", 1'b1, 1'b1, 1'b0, 3'd3, 16'h0401, 1'b1, 1'b0);
    tick();
    chk_all("new0a.done", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lmsm_seq

// File: doc/lmsm_seq.md
# lmsm_seq

Load-multiple/store-multiple sequencer for the pipelined RISC core. It sits between decode and the register-read stage. On an LM or SM instruction it expands the 8-bit register list into one single-register micro-op per set bit, lowest register first, at consecutive word addresses. Its per-micro-op register index and LM/SM tags drive the EX/MEM and MEM/WB pipeline fields that the load/store forwarding unit compares.

## Interface
- `REGS`, default 8: architectural registers; register-list width.
- `AW`, default 16: address width.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: decode presents a valid LM/SM instruction this cycle.
- `is_sm` input 1: 1 = SM (store-multiple), 0 = LM (load-multiple); sampled with `start`.
- `reg_list` input REGS: bit i set = transfer register i; sampled with `start`.
- `base_addr` input AW: address of the first transfer; sampled with `start`.
- `stall` input 1: downstream pipeline stall; holds the current micro-op.
- `busy` output 1: sequencer owns the issue slot; decode must hold the fetch/decode stages.
- `uop_valid` output 1: micro-op outputs are valid this cycle.
- `uop_lm` output 1: micro-op is a load (LM element).
- `uop_sm` output 1: micro-op is a store (SM element).
- `uop_reg` output log2(REGS): register index of this micro-op.
- `uop_addr` output AW: memory word address of this micro-op.
- `uop_last` output 1: this micro-op is the final one of the instruction.
- `done` output 1: one-cycle pulse when the instruction completes.

## Operation
- States: IDLE, RUN.
- IDLE, `start`=1, `reg_list`≠0:
  - capture `mask`←`reg_list`, `addr`←`base_addr`, `sm`←`is_sm`.
  - go to RUN.
- IDLE, `start`=1, `reg_list`=0:
  - stay in IDLE; no micro-op is issued.
  - `done` pulses next cycle.
- RUN is the only state with `busy`=`uop_valid`=1. In RUN:
  - `uop_reg` = index of the lowest set bit of `mask`.
  - `uop_addr` = `addr`.
  - `uop_sm` = `sm`, `uop_lm` = !`sm`.
  - `uop_last` = exactly one bit left in `mask`.
- RUN, `stall`=0 (micro-op accepted):
  - clear the lowest set bit of `mask`.
  - `addr` ← `addr`+1, mod 2^AW (0xFFFF wraps to 0x0000).
  - if `uop_last`, go to IDLE and pulse `done` next cycle.
- RUN, `stall`=1: all state and outputs hold unchanged.
- `start` while in RUN is ignored. Decode is stalled by `busy`, so decode must re-present the instruction.
- Outside RUN, `uop_valid`/`uop_lm`/`uop_sm`/`uop_last`=0 and `uop_reg`/`uop_addr`=0.
- `rst` (including mid-instruction):
  - next edge gives IDLE, `mask`=0, `addr`=0, `sm`=0.
  - all outputs 0.
  - any partial LM/SM is abandoned.

## Timing
- Reset values: every output 0.
- `start` is sampled at edge T. The first micro-op is valid in cycle T+1.
- A list with N set bits and no stalls:
  - micro-ops in cycles T+1 … T+N.
  - `done` high in cycle T+N+1.
- Each stall cycle extends the sequence by one cycle.
- `busy` is a registered state decode; it is not combinational from `start`. Decode inserts its own bubble in the `start` cycle.
- `done` is registered, one cycle wide. A `start` in the same cycle as `done` is accepted, giving back-to-back instructions with no dead cycle.
- Micro-op outputs are combinational from registers only. There is no input-to-output combinational path except through `stall`-gated state.

## Structure
- Shared package `risc_pkg` holds:
  - LM/SM opcode constants.
  - the `seq_state_t` enum {IDLE, RUN}.
  - `REG_IDX_W` = log2(REGS).
- Sub-module `lsb_pri_enc` computes:
  - `idx` = lowest set bit of a REGS-wide vector.
  - `one_left` = popcount==1.
  - `mask_next` = vector with the lowest set bit cleared.

## Test plan
- LM, `reg_list`=0x25, `base_addr`=0x0100, no stall:
  - micro-ops (reg, addr) = (0,0x0100), (2,0x0101), (5,0x0102), all with `uop_lm`=1.
  - `uop_last` on the third; `done` the following cycle.
- SM, `reg_list`=0xFF, `base_addr`=0xFFFE:
  - regs 0–7 in order, all with `uop_sm`=1.
  - addresses 0xFFFE, 0xFFFF, 0x0000 … 0x0005.
- `reg_list`=0x00 with `start`: `busy` stays 0, no `uop_valid`, `done` pulses at T+1.
- `reg_list`=0x81, `stall` high for 3 cycles during reg 0: reg 0/addr held for 4 cycles, then reg 7; `start` asserted mid-sequence is ignored.
- `rst` asserted while on the 2nd micro-op of 0x0F: next cycle all outputs 0 and `busy`=0; a new `start` then runs from its own `base_addr`.
- `start` coincident with `done`: second instruction's first micro-op appears the cycle after, with no gap.
